seq_mul_n: RTL and testbench
============================

// Module: seq_mul_n
// PURPOSE
//  Parametrised sequential shift-add multiplier, successor to the fixed 4-bit array multiplier.
//  Computes a WIDTH x WIDTH product in WIDTH iterations, one iteration per clock.
//  Supports unsigned or two's-complement signed operands, selected per transaction.
//  Valid/ready handshake on both input and output; sits between operand producers and result consumers.
// PARAMETERS
//  WIDTH   8   operand width in bits, >=2; product is 2*WIDTH bits
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, do not override)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands/mode valid
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  is_signed  in   1        1: a,b two's complement; 0: unsigned
//  out_valid  out  1        p holds a completed product
//  out_ready  in   1        consumer accepts p
//  p          out  2*WIDTH  product (signed or unsigned per captured is_signed)
//  busy       out  1        high in CALC or DONE
// BEHAVIOUR
//  Interface: one clock domain; rst_n asynchronous assert, synchronous deassert; rst_n=0 forces all
//    state/regs to reset values immediately.
//  Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, internal acc/count/regs=0.
//  FSM: IDLE -> CALC on in_valid&&in_ready (accept). CALC -> DONE when count==WIDTH-1 iteration done.
//    DONE -> IDLE on out_valid&&out_ready. No other transitions.
//  Accept: capture |a|,|b| (magnitude when is_signed and MSB=1, else raw), neg=is_signed&(a[MSB]^b[MSB]);
//    acc=0, count=0.
//  CALC, each cycle: if mplier[0] acc_hi = acc_hi + mcand (WIDTH+1-bit sum, carry kept);
//    then {carry,acc} shifted right 1, mplier shifted right 1; count++.
//  Exactly WIDTH CALC cycles regardless of operand values (no early exit).
//  DONE: p = neg ? -acc : acc (2*WIDTH-bit two's complement negate), registered on DONE entry;
//    out_valid=1.
//  Latency: accept on edge N -> out_valid high after edge N+WIDTH+1 (WIDTH=8: 9 cycles).
//  Back-pressure: in DONE with out_ready=0, p and out_valid hold stable indefinitely.
//  in_valid while busy: ignored, not queued; in_ready=0 throughout CALC and DONE.
//  Same-cycle out handshake and new in_valid: the result is consumed in DONE; the new operand is
//    accepted no earlier than the following cycle in IDLE (at most one transaction in flight).
//  Width rules: magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH bits unsigned; product of two
//    such magnitudes is 2^(2W-2) and fits in 2*WIDTH bits signed; no overflow possible in either mode.
//  Zero operand: still WIDTH cycles; result 0, never -0 (negate of 0 is 0).
//  Reset mid-CALC or mid-DONE: transaction discarded, out_valid=0, p=0, back to IDLE.
//  p only changes on DONE entry or reset; after a handshake p keeps its last value while out_valid=0.
// STRUCTURE
//  Package seq_mul_pkg: state enum {IDLE=2'd0, CALC=2'd1, DONE=2'd2}; localparam WIDTH_DEFAULT=8.
//  Sub-module add_n #(N) (ripple-carry adder built from fa_1 instances, N-bit + cin -> sum, cout)
//    used for the WIDTH-bit accumulate add; the final negate uses a 2*WIDTH-bit add_n with
//    inverted input and cin=1.
//  Top: FSM, counter, operand/acc shift registers, sign logic.
// TESTING (WIDTH=8 unless noted)
//  Unsigned 13*11, is_signed=0 -> p=16'h008F, out_valid exactly 9 cycles after accept.
//  Unsigned 255*255 -> p=16'hFE01; signed 8'h80*8'h80 (-128*-128) -> p=16'h4000.
//  Signed -3*5 (8'hFD,8'h05) -> p=16'hFFF1; signed 0*-7 -> p=16'h0000.
//  Back-pressure: out_ready=0 for 5 cycles in DONE -> p, out_valid stable; in_valid pulses during CALC
//    and DONE ignored.
//  rst_n low mid-CALC (iteration 4) -> out_valid=0, p=0, in_ready=1 immediately; next op 6*7 -> 16'h002A.
//  WIDTH=4 sweep: all 256 operand pairs, both modes, against reference model; latency 5 cycles.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
  localparam int WIDTH_DEFAULT = 8;
endpackage

// File: rtl/seq_mul_n_add.sv
// Full-adder cell and the N-bit ripple-carry adder built from it.
module fa_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  assign cout = c[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    fa_1 u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(sum[i]), .cout(c[i+1]));
  end
endmodule

// File: rtl/seq_mul_n.sv
// Sequential shift-add WIDTH x WIDTH multiplier, signed or unsigned per transaction,
// valid/ready on both sides, one transaction in flight.
module seq_mul_n
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_e               state;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;

  logic [WIDTH-1:0]     a_mag, b_mag, add_b, sum_hi;
  logic                 carry;
  logic [2*WIDTH-1:0]   acc_nxt, acc_neg, p_nxt;
  logic                 neg_cout;

  // |-2^(W-1)| wraps to 2^(W-1), which is still correct as a W-bit unsigned magnitude
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign add_b = mplier[0] ? mcand : '0;

  add_n #(.N(WIDTH)) u_acc_add (
    .a(acc[2*WIDTH-1:WIDTH]), .b(add_b), .cin(1'b0), .sum(sum_hi), .cout(carry)
  );

  assign acc_nxt = {carry, sum_hi, acc[WIDTH-1:1]};

  add_n #(.N(2*WIDTH)) u_neg_add (
    .a(~acc), .b({2*WIDTH{1'b0}}), .cin(1'b1), .sum(acc_neg), .cout(neg_cout)
  );

  // carry out of the negate only happens for acc==0, so a zero result is never flipped
  assign p_nxt = (neg && !neg_cout) ? acc_neg : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          mcand    <= a_mag;
          mplier   <= b_mag;
          neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc      <= '0;
          count    <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= CALC;
        end
        CALC: if (count == LAST) begin
          p         <= p_nxt;
          out_valid <= 1'b1;
          state     <= DONE;
        end else begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        DONE: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_n.sv
// Bench for seq_mul_n: directed and random WIDTH=8 operations plus a full WIDTH=4 sweep.
module tb_seq_mul_n;
  logic clk, rst_n;

  logic       iv8, rdy8, s8, ov8, or8, bsy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  logic       iv4, rdy4, s4, ov4, or4, bsy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  int checks = 0, failures = 0;

  seq_mul_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(bsy8)
  );

  seq_mul_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(bsy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Product taken from plain integer arithmetic on the interpreted operand values
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] av, input logic [7:0] bv,
                                          input bit s);
    longint mask, x, y;
    mask = (longint'(1) << w) - 1;
    x = longint'(av) & mask;
    y = longint'(bv) & mask;
    if (s && x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
    if (s && y >= (longint'(1) << (w - 1))) y -= (longint'(1) << w);
    return 16'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic set_in(input int w, input bit v, input logic [7:0] av, input logic [7:0] bv,
                        input bit s);
    if (w == 8) begin iv8 = v; a8 = av; b8 = bv; s8 = s; end
    else begin iv4 = v; a4 = av[3:0]; b4 = bv[3:0]; s4 = s; end
  endtask

  task automatic set_or(input int w, input bit r);
    if (w == 8) or8 = r; else or4 = r;
  endtask

  function automatic logic ov(input int w);   return (w == 8) ? ov8 : ov4;  endfunction
  function automatic logic rdy(input int w);  return (w == 8) ? rdy8 : rdy4; endfunction
  function automatic logic bsy(input int w);  return (w == 8) ? bsy8 : bsy4; endfunction
  function automatic logic [15:0] pv(input int w); return (w == 8) ? p8 : {8'h00, p4}; endfunction

  task automatic wait_done(input int w, input string tag, output int cyc);
    cyc = 0;
    while (!ov(w) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, w + 1);
  endtask

  // One full transaction; hold = DONE cycles with out_ready low, poke = in_valid noise while busy
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv, input bit s,
                        input int hold, input bit poke, input string tag);
    logic [15:0] exp;
    int cyc;
    exp = ref_mul(w, av, bv, s);
    @(negedge clk);
    chk({tag, "_rdy"}, rdy(w), 1);
    set_in(w, 1'b1, av, bv, s);
    @(posedge clk); #1;
    set_in(w, poke, ~av, ~bv, ~s);
    chk({tag, "_busy"}, {bsy(w), rdy(w)}, 2'b10);
    wait_done(w, tag, cyc);
    chk({tag, "_p"}, pv(w), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {ov(w), pv(w)}, {1'b1, exp});
    end
    @(negedge clk);
    set_in(w, 1'b0, 8'h00, 8'h00, 1'b0);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_post"}, {ov(w), rdy(w), bsy(w), pv(w)}, {3'b010, exp});
    set_or(w, 1'b0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    set_in(8, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0);
    or8 = 1'b0; or4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8", {rdy8, ov8, bsy8, p8}, {3'b100, 16'h0000});
    chk("rst4", {rdy4, ov4, bsy4, p4}, {3'b100, 8'h00});
    @(negedge clk) rst_n = 1'b1;

    run_op(8, 8'd13, 8'd11, 1'b0, 0, 1'b0, "u13x11");
    run_op(8, 8'hFF, 8'hFF, 1'b0, 0, 1'b0, "uFFxFF");
    run_op(8, 8'h80, 8'h80, 1'b1, 0, 1'b0, "s80x80");
    run_op(8, 8'hFD, 8'h05, 1'b1, 0, 1'b0, "sm3x5");
    run_op(8, 8'h00, 8'hF9, 1'b1, 0, 1'b0, "s0xm7");
    run_op(8, 8'h80, 8'h7F, 1'b1, 0, 1'b0, "s80x7F");
    run_op(8, 8'h2D, 8'hC3, 1'b1, 5, 1'b1, "bp");

    // result handshake and new operand in the same cycle: not accepted until IDLE
    run_op(8, 8'd20, 8'd3, 1'b0, 0, 1'b0, "pre");
    @(negedge clk);
    set_in(8, 1'b1, 8'd12, 8'd12, 1'b0);
    @(posedge clk); #1;
    wait_done(8, "same", cyc);
    @(negedge clk) or8 = 1'b1;
    @(posedge clk); #1;
    chk("same_noacc", {ov8, rdy8, bsy8}, 3'b010);
    @(negedge clk) or8 = 1'b0;
    @(posedge clk); #1;
    chk("same_acc", {rdy8, bsy8}, 2'b01);
    iv8 = 1'b0;
    wait_done(8, "same2", cyc);
    chk("same2_p", p8, 16'd144);
    @(negedge clk) or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;

    // reset during the calculation discards everything at once
    @(negedge clk);
    set_in(8, 1'b1, 8'd100, 8'd100, 1'b0);
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid", {ov8, rdy8, bsy8, p8}, {3'b010, 16'h0000});
    @(negedge clk) rst_n = 1'b1;
    run_op(8, 8'd6, 8'd7, 1'b0, 0, 1'b0, "u6x7");

    for (int i = 0; i < 30; i++)
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom), "rnd8");

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_op(4, 8'(x), 8'(y), 1'(s), 0, 1'b0, "sw4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
